// File: rtl/mem_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader_if
// Description : Valid/ready word stream carrying data read out of memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stream_reader_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader
// Description : Walks a wrap-around address range of a synchronous-read
//               memory and streams the words out on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW:0]         length,
  input  logic                abort,
  output logic [AW-1:0]       mem_address,
  input  logic [WIDTH-1:0]    mem_data,
  mem_stream_reader_if.master dout_if,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         words_sent
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_issue   = 3'd1;
  localparam logic [2:0] c_capture = 3'd2;
  localparam logic [2:0] c_present = 3'd3;
  localparam logic [2:0] c_finish  = 3'd4;

  localparam logic [AW:0] c_cnt_one = {{AW{1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [AW-1:0]    r_base;
  logic [AW:0]      r_length;

  logic [2:0]       w_state_nxt;
  logic [AW-1:0]    w_base_nxt;
  logic [AW:0]      w_length_nxt;
  logic [AW-1:0]    w_addr_nxt;
  logic [WIDTH-1:0] w_dout_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic [AW:0]      w_cnt_inc;
  logic             w_last;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  assign w_cnt_inc = words_sent + c_cnt_one;
  assign w_last    = (w_cnt_inc == r_length);

  // Every output is a flop loaded from its precomputed next value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state            <= c_idle;
      r_base             <= '0;
      r_length           <= '0;
      mem_address        <= '0;
      dout_if.dout       <= '0;
      dout_if.dout_valid <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      words_sent         <= '0;
    end else begin
      r_state            <= w_state_nxt;
      r_base             <= w_base_nxt;
      r_length           <= w_length_nxt;
      mem_address        <= w_addr_nxt;
      dout_if.dout       <= w_dout_nxt;
      dout_if.dout_valid <= w_valid_nxt;
      busy               <= w_busy_nxt;
      done               <= w_done_nxt;
      words_sent         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_state_nxt = (length == '0) ? c_finish : c_issue;
        end
      end
      c_issue:   w_state_nxt = abort ? c_idle : c_capture;
      c_capture: w_state_nxt = abort ? c_idle : c_present;
      c_present: begin
        if (abort) begin
          w_state_nxt = c_idle;
        end else if (dout_if.dout_ready) begin
          w_state_nxt = w_last ? c_finish : c_issue;
        end
      end
      c_finish:  w_state_nxt = c_idle;
      default:   w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_base_nxt   = r_base;
    w_length_nxt = r_length;
    w_addr_nxt   = mem_address;
    w_dout_nxt   = dout_if.dout;
    w_cnt_nxt    = words_sent;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_base_nxt   = base_addr;
          w_length_nxt = length;
          w_cnt_nxt    = '0;
          if (length != '0) begin
            w_addr_nxt = base_addr;
          end
        end
      end
      c_capture: w_dout_nxt = mem_data;
      c_present: begin
        // The next address is loaded on the handshake so ISSUE sees it valid.
        if (!abort && dout_if.dout_ready) begin
          w_cnt_nxt = w_cnt_inc;
          if (!w_last) begin
            w_addr_nxt = r_base + w_cnt_inc[AW-1:0];
          end
        end
      end
      default: ;
    endcase
    w_valid_nxt = (w_state_nxt == c_present);
    w_busy_nxt  = (w_state_nxt == c_issue) || (w_state_nxt == c_capture) ||
                  (w_state_nxt == c_present);
    w_done_nxt  = (w_state_nxt == c_finish);
  end

endmodule
`default_nettype wire

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side engine for the on-chip `memory` block. On a `start` command it walks a contiguous, wrap-around address range of the memory. It captures each word from the memory's synchronous read port and delivers the words in order on a valid/ready output stream. It sits between `memory` and any downstream consumer, and is the counterpart of the write path that fills the memory.

## Interface
- `width`, 32: memory word width in bits.
- `depth`, 256: number of memory words.
- `aw`, `$clog2(depth)` = 8: address width.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a transfer. Sampled only in IDLE.
- `base_addr`, input, `aw`: first word address. Sampled with `start`.
- `length`, input, `aw+1`: number of words, 0..`depth`. Sampled with `start`.
- `abort`, input, 1: synchronous cancel of the transfer in progress.
- `mem_address`, output, `aw`: address driven to `memory`.
- `mem_data`, input, `width`: the memory `data_out`, valid one cycle after `mem_address` is driven.
- `dout`, output, `width`: streamed word.
- `dout_valid`, output, 1: `dout` holds a word.
- `dout_ready`, input, 1: consumer accepts `dout`.
- `busy`, output, 1: a transfer is active.
- `done`, output, 1: one-cycle pulse when a transfer completes normally.
- `words_sent`, output, `aw+1`: handshakes completed in the current or last transfer.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, FINISH.
- **IDLE**
  - `start`=1 and `length`≠0: latch `base_addr` and `length`, clear `words_sent`, go to ISSUE.
  - `start`=1 and `length`=0: go straight to FINISH. No word is output.
- **ISSUE**: drive `mem_address` = `base_addr` + `words_sent`, modulo `depth`, then go to CAPTURE.
- **CAPTURE**: register `mem_data` into `dout`, then go to PRESENT.
- **PRESENT**: `dout_valid`=1.
  - `dout` and `dout_valid` are held stable until `dout_ready`=1.
  - On a handshake, increment `words_sent`. If the new count equals `length`, go to FINISH; otherwise go to ISSUE.
- **FINISH**: `done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic wraps: `depth-1` is followed by 0. With `length`=`depth`, every word is read exactly once.
- `start` outside IDLE is ignored and does not change the latched parameters.
- `abort`:
  - In ISSUE, CAPTURE or PRESENT it has priority over a handshake. Next state is IDLE, `dout_valid` drops, and `done` is not pulsed.
  - `words_sent` keeps its value.
  - In IDLE and FINISH, `abort` is ignored.
- `busy`=1 in ISSUE, CAPTURE and PRESENT; 0 in IDLE and FINISH.
- **Reset**: asserting `rst` low at any time, including mid-transfer, forces IDLE immediately. Reset values:
  - `mem_address`=0, `dout`=0, `dout_valid`=0
  - `busy`=0, `done`=0, `words_sent`=0

## Timing
- All outputs are registered. None depends combinationally on `dout_ready`, `start` or `abort`.
- `start` sampled at edge 0 → ISSUE in cycle 1, with `mem_address` valid in cycle 1.
- `mem_data` is valid in cycle 2 and captured at the end of cycle 2.
- `dout_valid`=1 from cycle 3. First-word latency is 3 cycles.
- Handshake in cycle N → ISSUE in cycle N+1 and the next `dout_valid` in cycle N+3. Best-case throughput is 1 word per 3 cycles.
- Final handshake in cycle N → `done`=1 and `busy`=0 in cycle N+1, IDLE in cycle N+2. A new `start` is accepted in cycle N+2.
- `length`=0: `start` at edge 0 → `done` in cycle 1.

## Test plan
- **Reset**
  - Hold `rst`=0 for 2 cycles with random inputs → all outputs stay 0.
  - Release `rst` → IDLE, `busy`=0.
- **Basic burst**
  - Memory preloaded with word[i] = 32'hA000_0000+i. `base_addr`=10, `length`=4, `dout_ready`=1.
  - `dout` sequence is A000_000A, A000_000B, A000_000C, A000_000D.
  - The first `dout_valid` is 3 cycles after `start`.
  - `done` pulses once, `words_sent`=4.
- **Backpressure**
  - Same burst with `dout_ready` low for 5 cycles on each word.
  - `dout` stays stable while `dout_valid` is high.
  - No word is lost or duplicated, and `mem_address` does not advance until the handshake.
- **Wrap-around**
  - `base_addr`=254, `length`=4.
  - `mem_address` sequence is 254, 255, 0, 1 and the matching data is streamed.
  - A second run with `length`=256 yields all 256 words.
- **Edge commands**
  - `length`=0 → `done` the cycle after `start`, no `dout_valid`.
  - `start` pulsed during PRESENT → ignored; the transfer completes with its original `length`.
- **Abort and reset mid-transfer**
  - `abort` during PRESENT of word 2, together with `dout_ready`=1 → IDLE next cycle, `dout_valid`=0, no `done`, `words_sent`=1.
  - `rst` low during CAPTURE → all outputs return to their reset values immediately.
  - A fresh `start` afterwards completes normally.
